// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage and MEM/WB register: byte-lane data memory with post-reset clear sequence.
module mem_stage #(
  parameter int BITS_SIZE     = 32,
  parameter int BITS_REGS     = 5,
  parameter int MEM_ADDR_BITS = 6
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [BITS_SIZE-1:0]     i_exmem_alu,
  input  logic [BITS_SIZE-1:0]     i_exmem_data_write,
  input  logic                     i_exmem_mem_read,
  input  logic                     i_exmem_mem_write,
  input  logic [1:0]               i_exmem_size,
  input  logic                     i_exmem_zero_extend,
  input  logic                     i_exmem_mem_to_reg,
  input  logic                     i_exmem_reg_write,
  input  logic                     i_exmem_lui,
  input  logic                     i_exmem_jal,
  input  logic                     i_exmem_halt,
  input  logic [BITS_SIZE-1:0]     i_exmem_extension,
  input  logic [BITS_SIZE-1:0]     i_exmem_pc8,
  input  logic [BITS_REGS-1:0]     i_exmem_register_dst,
  input  logic [MEM_ADDR_BITS-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0]     o_debug_data,
  output logic                     o_mem_ready,
  output logic [BITS_SIZE-1:0]     o_memwb_dato_mem,
  output logic [BITS_SIZE-1:0]     o_memwb_alu,
  output logic [BITS_SIZE-1:0]     o_memwb_extension,
  output logic [BITS_SIZE-1:0]     o_memwb_pc8,
  output logic [1:0]               o_memwb_size_filterL,
  output logic                     o_memwb_zero_extend,
  output logic                     o_memwb_mem_to_reg,
  output logic                     o_memwb_reg_write,
  output logic                     o_memwb_lui,
  output logic                     o_memwb_jal,
  output logic                     o_memwb_halt,
  output logic [BITS_REGS-1:0]     o_memwb_register_dst
);

  localparam int DEPTH = 2 ** MEM_ADDR_BITS;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic [BITS_SIZE-1:0]     mem_q [DEPTH];

  logic [MEM_ADDR_BITS-1:0] word_idx;
  logic [1:0]               lane;
  logic                     store;
  logic [3:0]               lane_we;
  logic [BITS_SIZE-1:0]     wr_data;
  logic [BITS_SIZE-1:0]     rd_word;
  logic [BITS_SIZE-1:0]     load_data;
  logic                     unused_addr_bits;

  logic [BITS_SIZE-1:0] dato_mem_q, alu_q, extension_q, pc8_q;
  logic [1:0]           size_q;
  logic                 zero_extend_q, mem_to_reg_q, reg_write_q, lui_q, jal_q, halt_q;
  logic [BITS_REGS-1:0] register_dst_q;

  // Upper address bits wrap onto the small memory.
  assign word_idx         = i_exmem_alu[MEM_ADDR_BITS+1:2];
  assign lane             = i_exmem_alu[1:0];
  assign unused_addr_bits = ^i_exmem_alu[BITS_SIZE-1:MEM_ADDR_BITS+2];
  assign store            = (state_q == ST_RUN) && i_enable && i_exmem_mem_write;
  assign rd_word          = mem_q[word_idx];

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {MEM_ADDR_BITS{1'b1}}) state_d = ST_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Store data is replicated across lanes so each lane enable picks its own slice.
  always_comb begin
    lane_we = 4'b0000;
    wr_data = i_exmem_data_write;
    case (i_exmem_size)
      2'b00: begin
        lane_we[lane] = 1'b1;
        wr_data       = {4{i_exmem_data_write[7:0]}};
      end
      2'b01: begin
        lane_we = i_exmem_alu[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_exmem_data_write[15:0]}};
      end
      default: lane_we = 4'b1111;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_cnt_q] <= '0;
      end else if (store) begin
        for (int l = 0; l < 4; l++) begin
          if (lane_we[l]) mem_q[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
        end
      end
    end
  end

  // Loads are right-aligned only; sign/zero filtering happens in WB.
  always_comb begin
    load_data = '0;
    if (i_exmem_mem_read) begin
      case (i_exmem_size)
        2'b00:   load_data = rd_word >> {lane, 3'b000};
        2'b01:   load_data = rd_word >> {i_exmem_alu[1], 4'b0000};
        default: load_data = rd_word;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || (state_q == ST_CLEAR)) begin
      dato_mem_q     <= '0;
      alu_q          <= '0;
      extension_q    <= '0;
      pc8_q          <= '0;
      size_q         <= '0;
      zero_extend_q  <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      reg_write_q    <= 1'b0;
      lui_q          <= 1'b0;
      jal_q          <= 1'b0;
      halt_q         <= 1'b0;
      register_dst_q <= '0;
    end else if (i_enable) begin
      dato_mem_q     <= load_data;
      alu_q          <= i_exmem_alu;
      extension_q    <= i_exmem_extension;
      pc8_q          <= i_exmem_pc8;
      size_q         <= i_exmem_size;
      zero_extend_q  <= i_exmem_zero_extend;
      mem_to_reg_q   <= i_exmem_mem_to_reg;
      reg_write_q    <= i_exmem_reg_write;
      lui_q          <= i_exmem_lui;
      jal_q          <= i_exmem_jal;
      halt_q         <= i_exmem_halt;
      register_dst_q <= i_exmem_register_dst;
    end
  end

  assign o_debug_data         = mem_q[i_debug_addr];
  assign o_mem_ready          = (state_q == ST_RUN);
  assign o_memwb_dato_mem     = dato_mem_q;
  assign o_memwb_alu          = alu_q;
  assign o_memwb_extension    = extension_q;
  assign o_memwb_pc8          = pc8_q;
  assign o_memwb_size_filterL = size_q;
  assign o_memwb_zero_extend  = zero_extend_q;
  assign o_memwb_mem_to_reg   = mem_to_reg_q;
  assign o_memwb_reg_write    = reg_write_q;
  assign o_memwb_lui          = lui_q;
  assign o_memwb_jal          = jal_q;
  assign o_memwb_halt         = halt_q;
  assign o_memwb_register_dst = register_dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized bench for mem_stage against a byte-addressed reference model.
module tb_mem_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, en, rd, wr, ze, m2r, rw, lui, jal, halt;
  logic [31:0] alu, dw, ext, pc8;
  logic [1:0]  size;
  logic [4:0]  dst;
  logic [5:0]  dbg_addr;

  logic [31:0] dbg_data, o_dato, o_alu, o_ext, o_pc8;
  logic        ready, o_ze, o_m2r, o_rw, o_lui, o_jal, o_halt;
  logic [1:0]  o_size;
  logic [4:0]  o_dst;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
    .i_exmem_alu(alu), .i_exmem_data_write(dw),
    .i_exmem_mem_read(rd), .i_exmem_mem_write(wr), .i_exmem_size(size),
    .i_exmem_zero_extend(ze), .i_exmem_mem_to_reg(m2r), .i_exmem_reg_write(rw),
    .i_exmem_lui(lui), .i_exmem_jal(jal), .i_exmem_halt(halt),
    .i_exmem_extension(ext), .i_exmem_pc8(pc8), .i_exmem_register_dst(dst),
    .i_debug_addr(dbg_addr), .o_debug_data(dbg_data), .o_mem_ready(ready),
    .o_memwb_dato_mem(o_dato), .o_memwb_alu(o_alu), .o_memwb_extension(o_ext),
    .o_memwb_pc8(o_pc8), .o_memwb_size_filterL(o_size),
    .o_memwb_zero_extend(o_ze), .o_memwb_mem_to_reg(o_m2r), .o_memwb_reg_write(o_rw),
    .o_memwb_lui(o_lui), .o_memwb_jal(o_jal), .o_memwb_halt(o_halt),
    .o_memwb_register_dst(o_dst)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory as 256 little-endian bytes; readiness from cycles since reset.
  logic [7:0]  m_mem [256];
  int          m_since;
  bit          m_valid = 1'b0;
  bit          m_ready;
  logic [31:0] e_dato, e_alu, e_ext, e_pc8;
  logic [1:0]  e_size;
  logic        e_ze, e_m2r, e_rw, e_lui, e_jal, e_halt;
  logic [4:0]  e_dst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int wi);
    return {m_mem[4*wi+3], m_mem[4*wi+2], m_mem[4*wi+1], m_mem[4*wi]};
  endfunction

  task automatic bubble();
    e_dato = 0; e_alu = 0; e_ext = 0; e_pc8 = 0; e_size = 0;
    e_ze = 0; e_m2r = 0; e_rw = 0; e_lui = 0; e_jal = 0; e_halt = 0; e_dst = 0;
  endtask

  task automatic model_step();
    int a, b;
    logic [31:0] w;
    if (rst) begin
      m_valid = 1'b1;
      m_since = 0;
      m_ready = 1'b0;
      bubble();
    end else if (m_valid) begin
      if (!m_ready) begin
        m_since++;
        bubble();
        if (m_since == DEPTH) begin
          m_ready = 1'b1;
          for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        end
      end else if (en) begin
        a = int'(alu[7:0]);
        w = mword(a / 4);
        if (!rd)          e_dato = 0;
        else if (size == 0) e_dato = w >> (8 * (a % 4));
        else if (size == 1) e_dato = w >> (16 * ((a / 2) % 2));
        else              e_dato = w;
        e_alu = alu; e_ext = ext; e_pc8 = pc8; e_size = size;
        e_ze = ze; e_m2r = m2r; e_rw = rw; e_lui = lui; e_jal = jal; e_halt = halt; e_dst = dst;
        if (wr) begin
          if (size == 0) m_mem[a] = dw[7:0];
          else if (size == 1) begin
            b = a - (a % 2);
            m_mem[b] = dw[7:0]; m_mem[b+1] = dw[15:8];
          end else begin
            b = a - (a % 4);
            for (int k = 0; k < 4; k++) m_mem[b+k] = dw[8*k +: 8];
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("ready", {31'd0, ready}, {31'd0, m_ready});
      chk("dato_mem", o_dato, e_dato);
      chk("alu", o_alu, e_alu);
      chk("extension", o_ext, e_ext);
      chk("pc8", o_pc8, e_pc8);
      chk("size", {30'd0, o_size}, {30'd0, e_size});
      chk("ctrl", {26'd0, o_ze, o_m2r, o_rw, o_lui, o_jal, o_halt},
                  {26'd0, e_ze, e_m2r, e_rw, e_lui, e_jal, e_halt});
      chk("register_dst", {27'd0, o_dst}, {27'd0, e_dst});
      if (m_ready) chk("debug_data", dbg_data, mword(int'(dbg_addr)));
    end
  end

  task automatic idle();
    en = 1; rd = 0; wr = 0; size = 0; alu = 0; dw = 0; ze = 0; m2r = 0; rw = 0;
    lui = 0; jal = 0; halt = 0; ext = 0; pc8 = 0; dst = 0;
  endtask

  task automatic mem_op(input logic r, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    idle();
    rd = r; wr = w; size = s; alu = a; dw = d;
    cycle();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      cycle();
      n++;
    end
    chk(name, n, 64);
  endtask

  task automatic randomize_inputs();
    en = ($urandom % 8) != 0;
    rd = $urandom % 2; wr = ($urandom % 3) == 0; size = 2'($urandom);
    alu = $urandom; dw = $urandom; ext = $urandom; pc8 = $urandom;
    ze = $urandom % 2; m2r = $urandom % 2; rw = $urandom % 2; lui = $urandom % 2;
    jal = $urandom % 2; halt = $urandom % 2; dst = 5'($urandom); dbg_addr = 6'($urandom);
  endtask

  initial begin
    idle();
    dbg_addr = 0;
    rst = 1;
    wr = 1; rd = 1; size = 2; dw = 32'hA5A5A5A5; alu = 32'h10; jal = 1; pc8 = 32'h44;
    cycle();
    cycle();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_dato", o_dato, 32'd0);
    rst = 0;
    wait_ready("clear_len");
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 6'(i);
      #1;
      chk("cleared_word", dbg_data, 32'd0);
    end

    mem_op(0, 1, 2'b10, 32'h10, 32'h11223344);
    mem_op(1, 0, 2'b00, 32'h11, 32'h0);
    chk("lb_0x11", o_dato, 32'h00112233);
    chk("lb_size", {30'd0, o_size}, 32'd0);
    mem_op(1, 0, 2'b01, 32'h12, 32'h0);
    chk("lh_0x12", o_dato, 32'h00001122);
    chk("lh_size", {30'd0, o_size}, 32'd1);

    dbg_addr = 6'd8;
    mem_op(0, 1, 2'b10, 32'h20, 32'hFFFFFFFF);
    mem_op(0, 1, 2'b00, 32'h22, 32'h000000AB);
    chk("sb_0x22", dbg_data, 32'hFFABFFFF);
    mem_op(0, 1, 2'b01, 32'h21, 32'h0000CDEF);
    chk("sh_0x21", dbg_data, 32'hFFABCDEF);
    mem_op(1, 1, 2'b10, 32'h20, 32'h01020304);
    chk("rw_same_cycle", o_dato, 32'hFFABCDEF);
    mem_op(1, 0, 2'b10, 32'h20, 32'h0);
    chk("raw_next_cycle", o_dato, 32'h01020304);

    idle();
    jal = 1; pc8 = 32'h48; dst = 5'd31; rw = 1;
    cycle();
    chk("jal", {31'd0, o_jal}, 32'd1);
    chk("jal_pc8", o_pc8, 32'h48);
    chk("jal_dato", o_dato, 32'd0);

    idle();
    en = 0; rd = 1; wr = 1; size = 2; alu = 32'h10; dw = 32'hDEADBEEF; dbg_addr = 6'd4;
    repeat (3) begin
      cycle();
      chk("frozen_jal", {31'd0, o_jal}, 32'd1);
      chk("frozen_pc8", o_pc8, 32'h48);
      chk("frozen_store", dbg_data, 32'h11223344);
    end
    en = 1; wr = 0;
    cycle();
    chk("unfrozen_dato", o_dato, 32'h11223344);
    chk("unfrozen_jal", {31'd0, o_jal}, 32'd0);

    repeat (1500) begin
      randomize_inputs();
      cycle();
    end

    idle();
    rst = 1;
    cycle();
    rst = 0;
    repeat (30) cycle();
    chk("midclear_ready", {31'd0, ready}, 32'd0);
    rst = 1;
    cycle();
    rst = 0;
    wait_ready("reclear_len");

    repeat (300) begin
      randomize_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
